// File: rtl/operand_serializer.sv
// Parallel-to-serial operand transmitter for the serial magnitude comparator (LSB-first).
// Optional feature macro: OPERAND_SERIALIZER_EXPECT_EN adds registered exp_greater/exp_equal/exp_less.
module operand_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             cmp_clr,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_valid,
  output logic             done,
  output logic             busy
`ifdef OPERAND_SERIALIZER_EXPECT_EN
  ,
  output logic             exp_greater,
  output logic             exp_equal,
  output logic             exp_less
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLR   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sh_a, sh_b, sh_a_nx, sh_b_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             accept;
  logic             last_bit;
  logic             cmp_clr_nx, ser_a_nx, ser_b_nx, ser_valid_nx, done_nx;

  assign accept   = in_valid && in_ready;
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE:  state_nx = accept ? S_CLR : S_IDLE;
      S_CLR:   state_nx = S_SHIFT;
      S_SHIFT: state_nx = last_bit ? S_DONE : S_SHIFT;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Shift registers and bit counter; counter saturates at WIDTH-1
  always_comb begin
    sh_a_nx = sh_a;
    sh_b_nx = sh_b;
    cnt_nx  = cnt;
    if (state == S_IDLE && accept) begin
      sh_a_nx = in_a;
      sh_b_nx = in_b;
      cnt_nx  = '0;
    end else if (state == S_SHIFT) begin
      sh_a_nx = sh_a >> 1;
      sh_b_nx = sh_b >> 1;
      if (!last_bit) cnt_nx = cnt + CNT_W'(1);
    end
  end

  // Output logic: handshake flags from state, everything else precomputed for registering
  always_comb begin
    in_ready     = (state == S_IDLE);
    busy         = (state != S_IDLE);
    cmp_clr_nx   = (state_nx == S_CLR);
    ser_valid_nx = (state_nx == S_SHIFT);
    ser_a_nx     = ser_valid_nx && sh_a_nx[0];
    ser_b_nx     = ser_valid_nx && sh_b_nx[0];
    done_nx      = (state_nx == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_a      <= '0;
      sh_b      <= '0;
      cnt       <= '0;
      cmp_clr   <= 1'b0;
      ser_a     <= 1'b0;
      ser_b     <= 1'b0;
      ser_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      sh_a      <= sh_a_nx;
      sh_b      <= sh_b_nx;
      cnt       <= cnt_nx;
      cmp_clr   <= cmp_clr_nx;
      ser_a     <= ser_a_nx;
      ser_b     <= ser_b_nx;
      ser_valid <= ser_valid_nx;
      done      <= done_nx;
    end
  end

`ifdef OPERAND_SERIALIZER_EXPECT_EN
  // Reference result captured at accept; resets to the comparator's equal state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_greater <= 1'b0;
      exp_equal   <= 1'b1;
      exp_less    <= 1'b0;
    end else if (state == S_IDLE && accept) begin
      exp_greater <= (in_a > in_b);
      exp_equal   <= (in_a == in_b);
      exp_less    <= (in_a < in_b);
    end
  end
`endif

endmodule

// File: doc/operand_serializer.md
# operand_serializer

Parallel-to-serial operand transmitter feeding the serial magnitude comparator. It accepts two WIDTH-bit unsigned operands over a valid/ready handshake and clears the comparator for one cycle. It then streams both operands LSB-first on `ser_a`/`ser_b` and flags the cycle in which the comparator's greater/equal/less outputs hold the final result. The comparator lets the most recent differing bit win, so LSB-first order yields a correct magnitude compare.

## Interface

- `WIDTH`, 8: operand width in bits; legal range ≥ 2.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset. Clock is `clk`.
- `in_valid` input 1: operand pair offered.
- `in_ready` output 1: block can accept; high only in IDLE.
- `in_a` input WIDTH: operand A, unsigned.
- `in_b` input WIDTH: operand B, unsigned.
- `cmp_clr` output 1: one-cycle clear pulse to the comparator's reset input.
- `ser_a` output 1: serial bit of A.
- `ser_b` output 1: serial bit of B.
- `ser_valid` output 1: a data bit pair is being driven.
- `done` output 1: one-cycle pulse; comparator result is valid this cycle.
- `busy` output 1: high in every state except IDLE.

## Operation

- FSM states: IDLE, CLR, SHIFT, DONE. Encoding is 2 bits; unused codes return to IDLE.
- IDLE: `in_ready`=1. On `in_valid && in_ready` at a rising edge, latch `in_a`/`in_b` into shift registers, clear the bit counter, and go to CLR.
- CLR: `cmp_clr`=1 for exactly one cycle. Next state is SHIFT.
- SHIFT: drive `ser_a`=`sh_a[0]`, `ser_b`=`sh_b[0]`, `ser_valid`=1.
  - Each edge shifts both registers right by one and increments the counter.
  - Stay for exactly WIDTH cycles; the counter runs 0..WIDTH-1, width $clog2(WIDTH).
  - On the edge where the counter equals WIDTH-1, go to DONE. The counter never wraps past WIDTH-1.
- DONE: `done`=1 for one cycle. Next state is IDLE.
- Idle-line rule: whenever `ser_valid`=0, `ser_a`=`ser_b`=0. Because the comparator holds state on equal bits, its result is stable in DONE and IDLE.
- `in_valid` while `busy` is ignored and nothing is latched. `in_a`/`in_b` may change freely after acceptance.
- All outputs except `in_ready` and `busy` are registered: no glitches on `cmp_clr`, `ser_*`, or `done`.
- Reset, including mid-SHIFT, aborts the operation:
  - State goes to IDLE; shift registers and counter go to 0.
  - A partial stream is discarded and never resumed.
  - The comparator shares `reset`, so it also returns to its equal state.

## Timing

- Reset values:
  - `in_ready`=1, `busy`=0.
  - `cmp_clr`=0, `ser_a`=0, `ser_b`=0, `ser_valid`=0, `done`=0.
- Accept edge E0 starts the sequence:
  - `cmp_clr` is high during E0..E1.
  - Bit i is driven during E(1+i)..E(2+i), for i=0..WIDTH-1.
  - `done` is high during E(WIDTH+1)..E(WIDTH+2).
  - `in_ready` returns high after E(WIDTH+2).
- The comparator samples bit i at edge E(2+i). Its outputs reflect the full compare during the `done` cycle.
- Minimum spacing between accepts is WIDTH+3 cycles (e.g. 11 for WIDTH=8).
- Latency from accept to `done` rising is WIDTH+1 edges.

## Configuration

- Macro `OPERAND_SERIALIZER_EXPECT_EN` adds a self-check reference.
- Defined:
  - Adds outputs `exp_greater`, `exp_equal`, `exp_less` (1 bit each).
  - They are registered at the accept edge from an unsigned compare of `in_a` against `in_b`, held until the next accept, and exactly one-hot.
  - Reset value: `exp_equal`=1, others 0, matching the comparator's reset state.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan

- WIDTH=8, `in_a`=0xA5, `in_b`=0x5A. Expected:
  - `ser_a` stream 1,0,1,0,0,1,0,1 and `ser_b` stream 0,1,0,1,1,0,1,0.
  - Comparator greater=1 in the `done` cycle.
  - `done` 9 edges after accept.
- `in_a`=`in_b`=0x3C → comparator equal=1 at `done`. With the macro defined, `exp_equal`=1.
- `in_a`=0x01, `in_b`=0x80 (LSB favours A, MSB favours B) → comparator less=1 at `done`. The last differing bit wins.
- Hold `in_valid`=1 continuously with changing operands → accepts are exactly 11 cycles apart. Operands presented while `busy` are never latched.
- Assert `reset` at the 4th SHIFT cycle → next cycle all outputs are at reset values and `in_ready`=1. A new accept of 0xFF vs 0x00 gives greater=1.
- Back-to-back pair 0x10 vs 0x20 then 0x20 vs 0x10 → `cmp_clr` pulses before each stream. Results are less, then greater, with no carry-over.
